// File: rtl/imm_gen_pipe_pkg.sv
// Shared constants for the immediate-generation pipeline: format codes and
// the legal output widths.
package imm_gen_pipe_pkg;

  localparam int unsigned IMM_SRC_W = 3;

  typedef enum logic [IMM_SRC_W-1:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_J     = 3'b011,
    IMM_U     = 3'b100,
    IMM_SHAMT = 3'b101,
    IMM_RSV6  = 3'b110,
    IMM_RSV7  = 3'b111
  } imm_src_e;

  function automatic bit width_ok(input int unsigned w);
    return (w == 32) || (w == 64);
  endfunction

endpackage

// File: rtl/imm_gen_pipe_extend.sv
// Combinational immediate extraction and extension for one instruction word.
// Reserved format codes yield a zero immediate with the illegal flag set.
module imm_extend
  import imm_gen_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [31:0]          instr,
  input  logic [IMM_SRC_W-1:0] imm_src,
  output logic [WIDTH-1:0]     imm,
  output logic                 illegal
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("imm_extend: WIDTH must be 32 or 64");
  end

  logic [31:0] base;
  logic        sext;

  always_comb begin
    base    = '0;
    sext    = 1'b1;
    illegal = 1'b0;
    case (imm_src_e'(imm_src))
      IMM_I: base = {{20{instr[31]}}, instr[31:20]};
      IMM_S: base = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: base = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J: base = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U: base = {instr[31:12], 12'h000};
      IMM_SHAMT: begin
        sext = 1'b0;
        base = {26'b0, ((WIDTH == 64) ? instr[25] : 1'b0), instr[24:20]};
      end
      default: begin
        sext    = 1'b0;
        illegal = 1'b1;
      end
    endcase
    // Upper bits carry the sign only when WIDTH exceeds the 32-bit base.
    imm       = sext ? {WIDTH{base[31]}} : '0;
    imm[31:0] = base;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a 1-cycle latency and a 2-entry skid buffer
// (output register + skid register), synchronous flush and illegal counter.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [IMM_SRC_W-1:0] in_imm_src,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_imm,
  output logic                 out_illegal,
  output logic [TAG_W-1:0]     out_tag,
  output logic [7:0]           illegal_cnt
);

  logic [WIDTH-1:0] ext_imm;
  logic             ext_illegal;

  imm_extend #(.WIDTH(WIDTH)) u_ext (
    .instr   (in_instr),
    .imm_src (in_imm_src),
    .imm     (ext_imm),
    .illegal (ext_illegal)
  );

  logic             skid_valid;
  logic [WIDTH-1:0] skid_imm;
  logic             skid_illegal;
  logic [TAG_W-1:0] skid_tag;
  logic             in_fire;
  logic             out_fire;
  logic             out_free;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_free = out_fire | ~out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_imm      <= '0;
      out_illegal  <= 1'b0;
      out_tag      <= '0;
      skid_valid   <= 1'b0;
      skid_imm     <= '0;
      skid_illegal <= 1'b0;
      skid_tag     <= '0;
      in_ready     <= 1'b1;
    end else if (flush) begin
      out_valid    <= 1'b0;
      out_imm      <= '0;
      out_illegal  <= 1'b0;
      out_tag      <= '0;
      skid_valid   <= 1'b0;
      skid_imm     <= '0;
      skid_illegal <= 1'b0;
      skid_tag     <= '0;
      in_ready     <= 1'b1;
    end else if (out_free) begin
      // in_ready is low while the skid is occupied, so a full skid never
      // coincides with an input transfer here.
      if (skid_valid) begin
        out_valid    <= 1'b1;
        out_imm      <= skid_imm;
        out_illegal  <= skid_illegal;
        out_tag      <= skid_tag;
        skid_valid   <= 1'b0;
        skid_imm     <= '0;
        skid_illegal <= 1'b0;
        skid_tag     <= '0;
      end else if (in_fire) begin
        out_valid   <= 1'b1;
        out_imm     <= ext_imm;
        out_illegal <= ext_illegal;
        out_tag     <= in_tag;
      end else begin
        out_valid   <= 1'b0;
        out_imm     <= '0;
        out_illegal <= 1'b0;
        out_tag     <= '0;
      end
      in_ready <= 1'b1;
    end else if (in_fire) begin
      skid_valid   <= 1'b1;
      skid_imm     <= ext_imm;
      skid_illegal <= ext_illegal;
      skid_tag     <= in_tag;
      in_ready     <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (!flush && in_fire && ext_illegal && (illegal_cnt != 8'hFF)) begin
      illegal_cnt <= illegal_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: WIDTH=32 and WIDTH=64 instances share stimulus and are
// compared against a 2-deep FIFO reference with arithmetic immediate decoding.
module tb_imm_gen_pipe;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             out_ready;
  logic [31:0]      in_instr;
  logic [2:0]       in_imm_src;
  logic [TAG_W-1:0] in_tag;

  logic             a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0]      a_out_imm;
  logic [TAG_W-1:0] a_out_tag;
  logic [7:0]       a_illegal_cnt;
  logic             b_in_ready, b_out_valid, b_out_illegal;
  logic [63:0]      b_out_imm;
  logic [TAG_W-1:0] b_out_tag;
  logic [7:0]       b_illegal_cnt;

  imm_gen_pipe #(.WIDTH(32), .TAG_W(TAG_W)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(a_in_ready), .in_instr(in_instr), .in_imm_src(in_imm_src),
    .in_tag(in_tag), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_imm(a_out_imm), .out_illegal(a_out_illegal), .out_tag(a_out_tag),
    .illegal_cnt(a_illegal_cnt)
  );

  imm_gen_pipe #(.WIDTH(64), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(b_in_ready), .in_instr(in_instr), .in_imm_src(in_imm_src),
    .in_tag(in_tag), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_imm(b_out_imm), .out_illegal(b_out_illegal), .out_tag(b_out_tag),
    .illegal_cnt(b_illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]      imm32;
    logic [63:0]      imm64;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } exp_t;

  exp_t        q[$];
  int unsigned ill_cnt;
  int          checks;
  int          failures;

  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src,
                                          input int w);
    longint signed si, hi, sg;
    logic [63:0]   u, r;
    si = $signed(ins);
    u  = {32'b0, ins};
    sg = si >>> 31;
    r  = 64'd0;
    case (src)
      3'd0: r = si >>> 20;
      3'd1: begin
        hi = si >>> 25;
        r  = (hi << 5) | ((u >> 7) & 64'd31);
      end
      3'd2: r = (sg << 12) | (((u >> 7) & 64'd1) << 11) | (((u >> 25) & 64'd63) << 5)
              | (((u >> 8) & 64'd15) << 1);
      3'd3: r = (sg << 20) | (((u >> 12) & 64'd255) << 12) | (((u >> 20) & 64'd1) << 11)
              | (((u >> 21) & 64'd1023) << 1);
      3'd4: begin
        hi = si >>> 12;
        r  = hi << 12;
      end
      3'd5: r = (u >> 20) & ((w == 32) ? 64'd31 : 64'd63);
      default: r = 64'd0;
    endcase
    if (w == 32) r = r & 64'h0000_0000_FFFF_FFFF;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    exp_t h;
    logic ev;
    ev = (q.size() > 0);
    if (ev) h = q[0];
    else    h = '{imm32: 64'd0, imm64: 64'd0, tag: '0, ill: 1'b0};
    chk("in_ready32",  64'(a_in_ready),    64'(q.size() < 2));
    chk("in_ready64",  64'(b_in_ready),    64'(q.size() < 2));
    chk("out_valid32", 64'(a_out_valid),   64'(ev));
    chk("out_valid64", 64'(b_out_valid),   64'(ev));
    chk("out_imm32",   64'(a_out_imm),     h.imm32);
    chk("out_imm64",   b_out_imm,          h.imm64);
    chk("out_tag32",   64'(a_out_tag),     64'(h.tag));
    chk("out_tag64",   64'(b_out_tag),     64'(h.tag));
    chk("out_ill32",   64'(a_out_illegal), 64'(h.ill));
    chk("out_ill64",   64'(b_out_illegal), 64'(h.ill));
    chk("ill_cnt32",   64'(a_illegal_cnt), 64'(ill_cnt));
    chk("ill_cnt64",   64'(b_illegal_cnt), 64'(ill_cnt));
  endtask

  // Reference behaviour at a rising edge, using the inputs held across it.
  task automatic model_edge();
    exp_t e;
    logic of, inf;
    if (!rst_n) begin
      q.delete();
      ill_cnt = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      of  = (q.size() > 0) && out_ready;
      inf = in_valid && (q.size() < 2);
      if (of) void'(q.pop_front());
      if (inf) begin
        e.imm32 = ref_imm(in_instr, in_imm_src, 32);
        e.imm64 = ref_imm(in_instr, in_imm_src, 64);
        e.tag   = in_tag;
        e.ill   = (in_imm_src >= 3'd6);
        q.push_back(e);
        if (e.ill && ill_cnt < 255) ill_cnt++;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] src,
                       input logic [TAG_W-1:0] tg, input logic rdy, input logic fl);
    in_valid   = v;
    in_instr   = ins;
    in_imm_src = src;
    in_tag     = tg;
    out_ready  = rdy;
    flush      = fl;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ill_cnt  = 0;
    rst_n    = 1'b1;
    drive(1'b0, 32'd0, 3'd0, '0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #2 check_all();
    @(posedge clk);
    model_edge();
    #1 rst_n = 1'b1;

    // Directed: I-format all-ones at WIDTH=32.
    drive(1'b1, 32'hFFF0_0093, 3'd0, 5'd3, 1'b1, 1'b0);
    cycle();
    chk("req033_imm", 64'(a_out_imm), 64'h0000_0000_FFFF_FFFF);
    chk("req033_ill", 64'(a_out_illegal), 64'd0);

    // Directed: U-format and shift amount at WIDTH=64.
    drive(1'b1, 32'h8000_02B7, 3'd4, 5'd4, 1'b1, 1'b0);
    cycle();
    chk("req034_u64", b_out_imm, 64'hFFFF_FFFF_8000_0000);
    drive(1'b1, 32'h03F0_1013, 3'd5, 5'd5, 1'b1, 1'b0);
    cycle();
    chk("req034_sh64", b_out_imm, 64'h3F);
    chk("req034_sh32", 64'(a_out_imm), 64'h1F);
    drive(1'b0, 32'd0, 3'd0, '0, 1'b1, 1'b0);
    cycle();

    // Backpressure: three pushes, only two accepted, FIFO order on release.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, 3'($urandom_range(0, 5)), 5'(10 + i), 1'b0, 1'b0);
      cycle();
      if (i == 1) chk("req035_ready_low", 64'(a_in_ready), 64'd0);
    end
    chk("req035_tag_first", 64'(a_out_tag), 64'd10);
    drive(1'b0, 32'd0, 3'd0, '0, 1'b1, 1'b0);
    cycle();
    chk("req035_tag_second", 64'(a_out_tag), 64'd11);
    cycle();
    chk("req035_empty", 64'(a_out_valid), 64'd0);

    // Flush with a full skid and a concurrent input.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, $urandom, 3'($urandom_range(0, 5)), 5'(16 + i), 1'b0, 1'b0);
      cycle();
    end
    drive(1'b1, 32'h1234_5678, 3'd1, 5'd20, 1'b0, 1'b1);
    cycle();
    chk("req036_valid", 64'(a_out_valid), 64'd0);
    chk("req036_ready", 64'(a_in_ready), 64'd1);
    drive(1'b0, 32'd0, 3'd0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle();

    // Saturating illegal counter.
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, $urandom, 3'd7, 5'($urandom), 1'b1, 1'b0);
      cycle();
    end
    chk("req037_sat", 64'(a_illegal_cnt), 64'd255);

    // Random traffic with a mid-stream asynchronous reset pulse.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom), 5'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
      cycle();
      if (i == 200) begin
        rst_n = 1'b0;
        #1;
        q.delete();
        ill_cnt = 0;
        check_all();
        chk("req037_rst_imm", b_out_imm, 64'd0);
        cycle();
        rst_n = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
